// File: rtl/cpuclk_gen_m.sv
// CPU clock generator on hsclk: follows synchronised BBC phi0 in LS mode, divides hsclk in HS mode,
// and changes mode only at phase boundaries so clkout never produces a runt pulse.
module cpuclk_gen_m #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 2
) (
    input  logic       hsclk,
    input  logic       resetb,
    input  logic       lsclk_in,
    input  logic       hsclk_sel,
    input  logic [1:0] hsclk_div_sel,
    output logic       clkout,
    output logic       hs_active,
    output logic       cycle_end
);

    typedef enum logic [1:0] {
        ST_LS,
        ST_HS,
        ST_HS2LS
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ls_s;
    logic                   ls_d;
    logic                   ls_rise;
    logic                   ls_fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       half_m1;
    logic                   clk_nxt;

    assign ls_s    = sync[SYNC_STAGES-1];
    assign ls_rise = ls_s & ~ls_d;
    assign ls_fall = ~ls_s & ls_d;
    // Reload value is the programmed half-period minus one.
    assign half_m1 = CNT_W'(hsclk_div_sel);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hsclk) begin
        if (!resetb) begin
            sync      <= '0;
            ls_d      <= 1'b0;
            state     <= ST_HS2LS;
            cnt       <= '0;
            clkout    <= 1'b0;
            hs_active <= 1'b0;
            cycle_end <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], lsclk_in};
            ls_d      <= ls_s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clkout    <= clk_nxt;
            hs_active <= (state_nxt == ST_HS);
            cycle_end <= clkout & ~clk_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clkout;
        unique case (state)
            ST_LS: begin
                clk_nxt = ls_s;
                if (ls_fall && hsclk_sel) begin
                    clk_nxt   = 1'b0;
                    cnt_nxt   = half_m1;
                    state_nxt = ST_HS;
                end
            end
            ST_HS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cnt_nxt = half_m1;
                    // Leave HS only as a full high phase ends, never mid-phase.
                    if (clkout && !hsclk_sel) begin
                        clk_nxt   = 1'b0;
                        state_nxt = ST_HS2LS;
                    end else begin
                        clk_nxt = ~clkout;
                    end
                end
            end
            ST_HS2LS: begin
                clk_nxt = 1'b0;
                if (ls_rise) begin
                    clk_nxt   = 1'b1;
                    state_nxt = ST_LS;
                end
            end
            default: begin
                clk_nxt   = 1'b0;
                state_nxt = ST_HS2LS;
            end
        endcase
    end

endmodule
